// File: rtl/pattern_loader_if.sv
// Byte-stream handshake between a pattern source (master) and pattern_loader (slave).
interface pattern_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid_in;
  logic       byte_ready_out;

  modport master (output byte_in, output byte_valid_in, input byte_ready_out);
  modport slave  (input byte_in, input byte_valid_in, output byte_ready_out);
endinterface

// File: rtl/pattern_loader.sv
// Streams a board pattern from a byte FIFO into the life cell buffer in lock-step with the raster scan.
// Optional feature macro PATTERN_LOADER_CRC_EN adds crc_out, a CRC-8 (poly 0x07) over consumed bytes.
module pattern_loader #(
  parameter int BOARD_DIM    = 32,
  parameter int FIFO_DEPTH   = 16,
  parameter int HCOUNT_WIDTH = 11,
  parameter int VCOUNT_WIDTH = 10
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  pattern_loader_if.slave         bus,
  input  logic [HCOUNT_WIDTH-1:0] hcount_in,
  input  logic [VCOUNT_WIDTH-1:0] vcount_in,
  input  logic                    hsync_in,
  input  logic                    vsync_in,
  input  logic                    blank_in,
  output logic [HCOUNT_WIDTH-1:0] hcount_out,
  output logic [VCOUNT_WIDTH-1:0] vcount_out,
  output logic                    hsync_out,
  output logic                    vsync_out,
  output logic                    blank_out,
  output logic                    alive_out,
  output logic                    wr_en_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    underrun_out
`ifdef PATTERN_LOADER_CRC_EN
  ,
  output logic [7:0]              crc_out
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [HCOUNT_WIDTH-1:0] H_LAST   = HCOUNT_WIDTH'(BOARD_DIM - 1);
  localparam logic [VCOUNT_WIDTH-1:0] V_LAST   = VCOUNT_WIDTH'(BOARD_DIM - 1);
  localparam logic [AW:0]             FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, LOAD} state_t;

  state_t                  state_q;
  logic [7:0]              mem_q [FIFO_DEPTH];
  logic [AW-1:0]           rd_ptr_q, wr_ptr_q;
  logic [AW:0]             count_q, count_d;
  logic                    ready_q;
  logic [2:0]              bit_idx_q;
  logic [HCOUNT_WIDTH-1:0] hcount_q;
  logic [VCOUNT_WIDTH-1:0] vcount_q;
  logic                    hsync_q, vsync_q, blank_q;
  logic                    alive_q, wr_en_q, done_q, underrun_q;

  logic                    at_origin, in_board, last_cell, write_cell;
  logic                    fifo_empty, push, pop;
  logic [7:0]              head_byte;

`ifdef PATTERN_LOADER_CRC_EN
  logic [7:0]              crc_q;

  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`endif

  // ARMED writes the origin pixel itself, so cell 0 is not lost on the transition to LOAD.
  always_comb begin
    at_origin  = (hcount_in == '0) && (vcount_in == '0);
    in_board   = (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
    last_cell  = (hcount_in == H_LAST) && (vcount_in == V_LAST);
    write_cell = !abort_in && in_board &&
                 ((state_q == LOAD) || ((state_q == ARMED) && at_origin));
    fifo_empty = (count_q == '0);
    head_byte  = mem_q[rd_ptr_q];
    pop        = write_cell && !fifo_empty && ((bit_idx_q == 3'd7) || last_cell);
    push       = bus.byte_valid_in && ready_q && !abort_in;
    count_d    = count_q;
    if (abort_in)          count_d = '0;
    else if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= bus.byte_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      bit_idx_q  <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      blank_q    <= 1'b0;
      alive_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
`ifdef PATTERN_LOADER_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      hcount_q <= hcount_in;
      vcount_q <= vcount_in;
      hsync_q  <= hsync_in;
      vsync_q  <= vsync_in;
      blank_q  <= blank_in;
      wr_en_q  <= write_cell;
      alive_q  <= write_cell && !fifo_empty && head_byte[bit_idx_q];
      done_q   <= write_cell && last_cell;

      // Ready follows the registered count, so a full FIFO refuses a push even while popping.
      count_q  <= count_d;
      ready_q  <= (count_d != FULL_CNT);
      if (abort_in) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end

      if (write_cell) begin
        bit_idx_q <= bit_idx_q + 3'd1;
        if (fifo_empty) underrun_q <= 1'b1;
      end
`ifdef PATTERN_LOADER_CRC_EN
      if (pop) crc_q <= crc8(crc_q, head_byte);
`endif

      case (state_q)
        IDLE: begin
          if (start_in && !abort_in) begin
            state_q    <= ARMED;
            underrun_q <= 1'b0;
            bit_idx_q  <= '0;
`ifdef PATTERN_LOADER_CRC_EN
            crc_q      <= '0;
`endif
          end
        end
        ARMED:   if (write_cell) state_q <= last_cell ? IDLE : LOAD;
        LOAD:    if (write_cell && last_cell) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (abort_in) state_q <= IDLE;
    end
  end

  assign bus.byte_ready_out = ready_q;
  assign hcount_out         = hcount_q;
  assign vcount_out         = vcount_q;
  assign hsync_out          = hsync_q;
  assign vsync_out          = vsync_q;
  assign blank_out          = blank_q;
  assign alive_out          = alive_q;
  assign wr_en_out          = wr_en_q;
  assign busy_out           = (state_q != IDLE);
  assign done_out           = done_q;
  assign underrun_out       = underrun_q;
`ifdef PATTERN_LOADER_CRC_EN
  assign crc_out            = crc_q;
`endif

endmodule
